i2s_receiver: RTL and testbench
===============================

Name: i2s_receiver

Overview:
- I2S slave receiver: the inverse of the synth's I2S transmitter. It samples external bclk/ws/sd lines in the master_clk domain (12.288 MHz; bclk 3.072 MHz, 48 kHz frames).
- Deserialises MSB-first words and presents a stereo left/right sample pair with a one-cycle valid strobe.
- Used for line-in capture and as the loopback checker for the transmitter.

Parameters:
- SAMPLE_WIDTH, 16: bits kept per channel word (MSB-first).
- TIMEOUT_CYCLES, 64: clk cycles with no bclk rising edge before lock is dropped.

Ports:
- clk  in  1  system clock (master_clk, 12.288 MHz)
- rst  in  1  asynchronous, active-low reset
- i2s_bclk  in  1  external bit clock; async to clk
- i2s_ws  in  1  external word select; 0 = left, 1 = right
- i2s_sd  in  1  external serial data
- left_sample  out  SAMPLE_WIDTH  last completed left word
- right_sample  out  SAMPLE_WIDTH  last completed right word
- sample_valid  out  1  one-clk pulse when a new L+R pair is committed
- locked  out  1  high while word alignment is established

Behaviour:
- Reset (rst=0, async): all synchroniser flops 0; left_sample=0, right_sample=0, sample_valid=0, locked=0; state=ACQUIRE; bit counter, shift register, left_seen and ws_q all 0.
- Synchronisation: bclk, ws and sd each pass through a 2-FF synchroniser. A third bclk flop provides edge detection. A bclk rising edge (rise) is detected 3 clk after the pin edge. ws and sd are sampled on the rise cycle.
- ws_q: holds ws as sampled at the previous rise. A boundary is a rise where sampled ws != ws_q. In I2S timing the bit sampled at a boundary is the LSB of the word tagged ws_q.
- States:
  - ACQUIRE: ignore data. On the first boundary: clear the counter and shift register, go to RECEIVE, set locked=1 on the next clk.
  - RECEIVE: on each rise, if bit_cnt < SAMPLE_WIDTH, write sd to shreg[SAMPLE_WIDTH-1-bit_cnt]. bit_cnt is 6 bits, increments and saturates at 63; bits past SAMPLE_WIDTH are discarded.
- Commit (RECEIVE, at a boundary, after the current bit is captured):
  - The word is shreg; short words are left-justified and zero-padded at the LSBs.
  - Then clear shreg and bit_cnt.
  - ws_q=0 (left word): load left_sample and set left_seen.
  - ws_q=1 (right word): load right_sample. If left_seen, pulse sample_valid for exactly 1 clk on the same cycle the registers update, then clear left_seen.
  - A right word with no preceding left word updates right_sample only; no pulse is issued.
- sample_valid latency: 1 clk after the rise cycle of the right-word LSB, i.e. 4 clk after the pin edge.
- Timeout: the watchdog counter resets on every rise. Reaching TIMEOUT_CYCLES sends the state to ACQUIRE, clears locked, left_seen and bit_cnt, and leaves left_sample and right_sample unchanged.
- Outputs hold their values between commits. The block never back-pressures; a downstream that misses a pulse loses that frame.
- ws toggling on consecutive rises gives 1-bit words: commit MSB-only values, no error.
- Reset asserted mid-word: immediate return to the reset values; the partial word is lost.

Optional Feature:
- Macro I2S_RX_FRAME_ERR_EN.
- Enabled:
  - Extra output port frame_err (1 bit, reset 0), which pulses 1 clk at any commit whose word length (bit_cnt+1) is < SAMPLE_WIDTH or > 32.
  - Extra sticky port err_seen (1 bit), set by any frame_err and cleared only by rst.
  - Sample updates happen regardless of error.
- Disabled: neither port exists and no checking logic is built.

Test Plan:
1. Reset, then drive standard 32-bit-slot I2S frames: L=0x1234, R=0xABCD, zero-padded to 32 bits -> first boundary sets locked; after the second full frame, sample_valid=1 for one clk with left_sample=0x1234 and right_sample=0xABCD.
2. Drive 8 consecutive frames of ramp data (L=n, R=~n) -> exactly one sample_valid per frame, 4 clk after the right-word LSB rise; all values match.
3. Drive 12-bit words: L=0xABC, R=0x123 -> left_sample=0xABC0 and right_sample=0x1230. With I2S_RX_FRAME_ERR_EN, frame_err pulses twice per frame and err_seen=1.
4. Start the stream mid-right-word after reset -> partial data discarded; the first sample_valid carries only complete words from the following frame.
5. Stop bclk for 80 clk mid-word -> locked falls at 64 clk, samples are retained, no sample_valid is issued. On restart, locked re-asserts at the first boundary, and the first pair is valid only after a full L+R.
6. Assert rst=0 asynchronously between clk edges mid-frame -> all outputs read 0 immediately. After release, locked=0 until the next boundary.

Source files
------------

// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// I2S slave receiver. The external bit clock, word select and serial data
// lines are brought into the clk domain through two-flop synchronisers and
// bclk rising edges are detected with a third bclk flop. Words are shifted
// in MSB-first. A word ends at a "boundary", which is a bclk rise where the
// sampled word select differs from the value seen at the previous rise. The
// bit sampled at a boundary is the LSB of the word that is ending. A
// completed left word followed by a completed right word produces a
// one-cycle sample_valid strobe.
//
// Ports:
//   clk           system clock (master_clk)
//   rst           asynchronous, active-low reset
//   i2s_bclk      external bit clock, asynchronous to clk
//   i2s_ws        external word select (0 = left, 1 = right)
//   i2s_sd        external serial data, MSB first
//   left_sample   last completed left word
//   right_sample  last completed right word
//   sample_valid  one-clk pulse when a new L+R pair is committed
//   locked        high while word alignment is established
//
// Optional build macro I2S_RX_FRAME_ERR_EN adds:
//   frame_err     one-clk pulse on a commit whose word length is below
//                 SAMPLE_WIDTH or above 32 bits
//   err_seen      sticky copy of frame_err, cleared only by rst
// ---------------------------------------------------------------------------
module i2s_receiver #(
  parameter int unsigned SAMPLE_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i2s_bclk,
  input  logic                    i2s_ws,
  input  logic                    i2s_sd,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    locked
`ifdef I2S_RX_FRAME_ERR_EN
  ,
  output logic                    frame_err,
  output logic                    err_seen
`endif
);

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_RECEIVE = 1'b1;

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronisers
  logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic r_ws_s1, r_ws_s2;
  logic r_sd_s1, r_sd_s2;

  // Receive state
  logic [0:0]              r_state;
  logic                    r_ws_q;
  logic [5:0]              r_bit_cnt;
  logic [SAMPLE_WIDTH-1:0] r_shreg;
  logic                    r_left_seen;
  logic [WD_W-1:0]         r_wdog;

  logic                    w_rise;
  logic                    w_boundary;
  logic                    w_timeout;
  logic [SAMPLE_WIDTH-1:0] w_shreg_cap;

  // ---------------------------------------------------------------------
  // Input synchronisation and bclk rise detection
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_s3 <= 1'b0;
      r_ws_s1   <= 1'b0;
      r_ws_s2   <= 1'b0;
      r_sd_s1   <= 1'b0;
      r_sd_s2   <= 1'b0;
    end else begin
      r_bclk_s1 <= i2s_bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_s3 <= r_bclk_s2;
      r_ws_s1   <= i2s_ws;
      r_ws_s2   <= r_ws_s1;
      r_sd_s1   <= i2s_sd;
      r_sd_s2   <= r_sd_s1;
    end
  end

  assign w_rise     = r_bclk_s2 & ~r_bclk_s3;
  assign w_boundary = w_rise & (r_ws_s2 != r_ws_q);

  // ---------------------------------------------------------------------
  // bclk watchdog: counts clk cycles since the last rise and saturates at
  // TIMEOUT_CYCLES, so the timeout fires exactly once per stall.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (w_rise) begin
      r_wdog <= '0;
    end else if (r_wdog != WD_W'(TIMEOUT_CYCLES)) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = ~w_rise & (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // ---------------------------------------------------------------------
  // Shift register with the current bit merged in. The commit uses this
  // merged value so the LSB sampled at a boundary belongs to the word that
  // is ending. Bits beyond SAMPLE_WIDTH match no position and are dropped.
  // ---------------------------------------------------------------------
  always_comb begin
    w_shreg_cap = r_shreg;
    for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
      if (r_bit_cnt == 6'(SAMPLE_WIDTH - 1 - i)) begin
        w_shreg_cap[i] = r_sd_s2;
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  logic [6:0] w_word_len;
  logic       w_len_bad;

  assign w_word_len = {1'b0, r_bit_cnt} + 7'd1;
  assign w_len_bad  = (w_word_len < 7'(SAMPLE_WIDTH)) || (w_word_len > 7'd32);
`endif

  // ---------------------------------------------------------------------
  // Alignment FSM, deserialiser and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_ACQUIRE;
      r_ws_q       <= 1'b0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_left_seen  <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      frame_err    <= 1'b0;
      err_seen     <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif

      // ws_q tracks every rise in both states so the first boundary after
      // (re)acquisition is judged against the true previous word select.
      if (w_rise) begin
        r_ws_q <= r_ws_s2;
      end

      if (w_timeout) begin
        r_state     <= ST_ACQUIRE;
        locked      <= 1'b0;
        r_left_seen <= 1'b0;
        r_bit_cnt   <= '0;
      end else if (w_rise) begin
        case (r_state)
          ST_ACQUIRE: begin
            if (w_boundary) begin
              r_bit_cnt <= '0;
              r_shreg   <= '0;
              r_state   <= ST_RECEIVE;
              locked    <= 1'b1;
            end
          end

          ST_RECEIVE: begin
            if (w_boundary) begin
              r_shreg   <= '0;
              r_bit_cnt <= '0;
              if (!r_ws_q) begin
                left_sample <= w_shreg_cap;
                r_left_seen <= 1'b1;
              end else begin
                right_sample <= w_shreg_cap;
                if (r_left_seen) begin
                  sample_valid <= 1'b1;
                  r_left_seen  <= 1'b0;
                end
              end
`ifdef I2S_RX_FRAME_ERR_EN
              frame_err <= w_len_bad;
              if (w_len_bad) begin
                err_seen <= 1'b1;
              end
`endif
            end else begin
              r_shreg <= w_shreg_cap;
              if (r_bit_cnt != 6'd63) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end
          end

          default: begin
            r_state <= ST_ACQUIRE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam int SW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bclk = 1'b0;
  logic          ws = 1'b0;
  logic          sd = 1'b0;
  logic [SW-1:0] left_sample;
  logic [SW-1:0] right_sample;
  logic          sample_valid;
  logic          locked;
`ifdef I2S_RX_FRAME_ERR_EN
  logic          frame_err;
  logic          err_seen;
  int            n_ferr = 0;
`endif

  always #5 clk = ~clk;

  i2s_receiver #(
    .SAMPLE_WIDTH   (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i2s_bclk     (bclk),
    .i2s_ws       (ws),
    .i2s_sd       (sd),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .locked       (locked)
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    .frame_err    (frame_err),
    .err_seen     (err_seen)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    int            rise;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          nbits;
    bit          pulse;
    logic [SW-1:0] el;
    logic [SW-1:0] er;
  } frame_t;

  frame_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected pair and arrive
  // 3..4 clk after the right-word LSB rise was driven on the pin.
  always @(negedge clk) begin
    if (rst && sample_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   d;
        e = sb.pop_front();
        d = cyc - e.rise;
        chk("left_sample", left_sample, e.l);
        chk("right_sample", right_sample, e.r);
        chk("valid_latency_3to4", (d >= 3 && d <= 4) ? 32'd1 : 32'd0, 32'd1);
      end
    end
`ifdef I2S_RX_FRAME_ERR_EN
    if (rst && frame_err) n_ferr++;
`endif
  end

  // One bit per 4 clk: bclk low 2 clk with data set up, high 2 clk.
  // Caller is aligned to a clk negedge.
  task automatic send_bit(input logic ws_v, input logic sd_v);
    bclk = 1'b0;
    ws   = ws_v;
    sd   = sd_v;
    @(negedge clk);
    @(negedge clk);
    bclk      = 1'b1;
    last_rise = cyc;
    @(negedge clk);
    @(negedge clk);
  endtask

  // I2S: ws switches to the next word's value on the LSB of this word.
  task automatic send_word(input logic [31:0] val, input int nbits,
                           input logic ws_v, input logic next_ws);
    for (int i = nbits - 1; i >= 0; i--) begin
      send_bit((i == 0) ? next_ws : ws_v, val[i]);
    end
  endtask

  task automatic send_frame(input frame_t f);
    exp_t e;
    send_word(f.l, f.nbits, 1'b0, 1'b1);
    send_word(f.r, f.nbits, 1'b1, 1'b0);
    if (f.pulse) begin
      e.l    = f.el;
      e.r    = f.er;
      e.rise = last_rise;
      sb.push_back(e);
    end
  endtask

  function automatic frame_t mk(input logic [31:0] l, input logic [31:0] r, input int nbits,
                                input bit pulse, input logic [SW-1:0] el, input logic [SW-1:0] er);
    frame_t f;
    f.l = l; f.r = r; f.nbits = nbits; f.pulse = pulse; f.el = el; f.er = er;
    return f;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [15:0] nv;
    int          t0;
    int          drop;

    // Vector table: test 1 frames, ramp, 24-bit, 12-bit and 1-bit words.
    tbl.push_back(mk(32'h1234_0000, 32'hABCD_0000, 32, 1'b0, 16'h0000, 16'hABCD));
    tbl.push_back(mk(32'h1234_0000, 32'hABCD_0000, 32, 1'b1, 16'h1234, 16'hABCD));
    for (int n = 1; n <= 8; n++) begin
      nv = 16'(n);
      tbl.push_back(mk({nv, 16'h0}, {~nv, 16'h0}, 32, 1'b1, nv, ~nv));
    end
    tbl.push_back(mk(32'h00AB_CDEF, 32'h0013_579B, 24, 1'b1, 16'hABCD, 16'h1357));
    tbl.push_back(mk(32'h0000_0ABC, 32'h0000_0123, 12, 1'b1, 16'hABC0, 16'h1230));
    tbl.push_back(mk(32'h0000_0ABC, 32'h0000_0123, 12, 1'b1, 16'hABC0, 16'h1230));
    tbl.push_back(mk(32'h1, 32'h0, 1, 1'b1, 16'h8000, 16'h0000));
    tbl.push_back(mk(32'h0, 32'h1, 1, 1'b1, 16'h0000, 16'h8000));

    // Reset state
    wait_clk(3);
    chk("rst_left", left_sample, 16'h0);
    chk("rst_right", right_sample, 16'h0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    rst = 1'b1;
    wait_clk(2);

    // Tests 1-3 plus 1-bit words, one continuous stream
    for (int i = 0; i < tbl.size(); i++) begin
`ifdef I2S_RX_FRAME_ERR_EN
      if (i == 11) begin
        chk("err_seen_clean", err_seen, 1'b0);
        n_ferr = 0;
      end
`endif
      send_frame(tbl[i]);
      if (i == 0) begin
        wait_clk(2);
        chk("t1_locked", locked, 1'b1);
        chk("t1_right_only", right_sample, 16'hABCD);
        chk("t1_left_untouched", left_sample, 16'h0000);
      end
`ifdef I2S_RX_FRAME_ERR_EN
      if (i == 12) begin
        wait_clk(2);
        chk("frame_err_pulses", n_ferr, 4);
        chk("err_seen_set", err_seen, 1'b1);
      end
`endif
    end
    wait_clk(4);
    chk("drain_table", sb.size(), 0);

    // Test 4: stream starts mid-right-word after reset
    rst = 1'b0;
    bclk = 1'b0; ws = 1'b0; sd = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    wait_clk(2);
    chk("t4_locked", locked, 1'b1);
    chk("t4_partial_right", right_sample, 16'hF000);
    send_frame(mk(32'h5A5A_0000, 32'h0F0F_0000, 32, 1'b1, 16'h5A5A, 16'h0F0F));

    // Test 5: bclk stall mid-left-word
    send_frame(mk(32'h1111_0000, 32'h2222_0000, 32, 1'b1, 16'h1111, 16'h2222));
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    chk("t5_locked_before_stall", locked, 1'b1);
    t0 = last_rise;
    drop = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!locked) begin
        drop = cyc - t0;
        break;
      end
    end
    chk("t5_lock_drop_64to70", (drop >= TO && drop <= TO + 6) ? 32'd1 : 32'd0, 32'd1);
    while (cyc - t0 < 80) @(negedge clk);
    chk("t5_unlocked", locked, 1'b0);
    chk("t5_left_kept", left_sample, 16'h1111);
    chk("t5_right_kept", right_sample, 16'h2222);
    send_frame(mk(32'h3333_0000, 32'h4444_0000, 32, 1'b0, 16'h0, 16'h0));
    wait_clk(2);
    chk("t5_relocked", locked, 1'b1);
    chk("t5_right_only", right_sample, 16'h4444);
    chk("t5_left_kept2", left_sample, 16'h1111);
    send_frame(mk(32'h5555_0000, 32'h6666_0000, 32, 1'b1, 16'h5555, 16'h6666));

    // Test 6: asynchronous reset between clk edges mid-frame
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
    chk("t6_drain", sb.size(), 0);
    chk("t6_locked_before", locked, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    bclk = 1'b0;
    #1;
    chk("t6_left_zero", left_sample, 16'h0);
    chk("t6_right_zero", right_sample, 16'h0);
    chk("t6_valid_zero", sample_valid, 1'b0);
    chk("t6_locked_zero", locked, 1'b0);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    wait_clk(2);
    chk("t6_no_boundary_unlocked", locked, 1'b0);
    send_bit(1'b1, 1'b0);
    wait_clk(1);
    chk("t6_boundary_locked", locked, 1'b1);

    wait_clk(10);
    chk("final_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
